// File: rtl/shift_fu_pipe.sv
// -----------------------------------------------------------------------------
// shift_fu_pipe
//
// Pipelined shift/rotate functional unit with an in-order output queue that
// delivers each result to the ROB and, unless flags[7] is set, to the CDB.
// The head entry is held until every channel it needs has been granted.
//
// Operations (operand[3:0]): 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR, others -> 0.
// Logical and arithmetic shifts saturate for amounts >= WIDTH. Rotates use the
// amount modulo WIDTH.
//
// Parameters
//   WIDTH    data width of operands and result
//   ROBID_W  ROB tag width
//   LATENCY  accept-to-queue-write stages, legal 1..4 (1 = written at accept)
//   QDEPTH   output queue depth and cap on ops in flight, minimum 1
//
// Ports
//   clk, rst                  clock (rising edge), async active-high reset
//   input_transmit            issue valid
//   operand[7:0]              opcode in bits [3:0]
//   depvals[1]/[0]            a (value) / b (unsigned shift amount)
//   wbs, flags, robid         sideband carried unchanged with the op
//   flush                     drop every in-flight and queued op
//   cdb_transmit              CDB grant
//   cdb_transmit_out, cdb_id, cdb_val                       CDB request
//   rob_transmit              ROB grant
//   rob_transmit_out, robid_out, flags_out, wbs_out, value_out  ROB request
//   busy                      issue stall (registered occupancy >= QDEPTH)
// -----------------------------------------------------------------------------
module shift_fu_pipe #(
    parameter int WIDTH   = 8,
    parameter int ROBID_W = 4,
    parameter int LATENCY = 1,
    parameter int QDEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       input_transmit,
    input  logic [7:0]                 operand,
    input  logic [1:0][WIDTH-1:0]      depvals,
    input  logic [7:0]                 wbs,
    input  logic [7:0]                 flags,
    input  logic [ROBID_W-1:0]         robid,
    input  logic                       flush,
    input  logic                       cdb_transmit,
    output logic                       cdb_transmit_out,
    output logic [ROBID_W-1:0]         cdb_id,
    output logic [WIDTH-1:0]           cdb_val,
    input  logic                       rob_transmit,
    output logic                       rob_transmit_out,
    output logic [ROBID_W-1:0]         robid_out,
    output logic [7:0]                 flags_out,
    output logic [7:0]                 wbs_out,
    output logic [WIDTH-1:0]           value_out,
    output logic                       busy
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);

    // WIDTH expressed at operand width (+1 bit) so comparisons stay width-exact.
    localparam logic [WIDTH:0]   W_EXT = (WIDTH + 1)'(WIDTH);
    localparam logic [WIDTH-1:0] W_MOD = WIDTH'(WIDTH);

    typedef enum logic [3:0] {
        OP_SLL = 4'd0,
        OP_SRL = 4'd1,
        OP_SRA = 4'd2,
        OP_ROL = 4'd3,
        OP_ROR = 4'd4
    } op_e;

    typedef struct packed {
        logic [WIDTH-1:0]   value;
        logic [7:0]         wbs;
        logic [7:0]         flags;
        logic [ROBID_W-1:0] robid;
    } entry_t;

    // -------------------------------------------------------------------------
    // Shift datapath
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] shift_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic                 sat;
        logic [WIDTH-1:0]     amt;
        logic [2*WIDTH-1:0]   dbl;
        logic [WIDTH-1:0]     res;
        // NOTE: every local gets a value before the case so no path leaves a
        // variable unassigned; in always_comb the same habit prevents latches.
        sat = ({1'b0, b} >= W_EXT);
        amt = b % W_MOD;
        dbl = {a, a};
        res = '0;
        case (op)
            OP_SLL: res = sat ? '0 : (a << b);
            OP_SRL: res = sat ? '0 : (a >> b);
            OP_SRA: res = sat ? {WIDTH{a[WIDTH-1]}} : WIDTH'($signed(a) >>> b);
            OP_ROL: begin
                // Bits shifted out of the upper copy are refilled from the lower.
                dbl = dbl << amt;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = dbl >> amt;
                res = dbl[WIDTH-1:0];
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    // Upper opcode bits carry no meaning for this unit.
    logic unused_opbits;
    assign unused_opbits = ^operand[7:4];

    logic   accept;
    entry_t in_entry;
    logic   wr_en;
    entry_t wr_data;

    assign accept   = input_transmit && !busy && !flush;
    assign in_entry = '{value: shift_result(operand[3:0], depvals[1], depvals[0]),
                        wbs:   wbs,
                        flags: flags,
                        robid: robid};

    // -------------------------------------------------------------------------
    // Pipeline: LATENCY-1 register stages between accept and queue write.
    // The occupancy cap guarantees the queue has room when a stage drains, so
    // the pipeline never needs to stall.
    // -------------------------------------------------------------------------
    generate
        if (LATENCY <= 1) begin : g_direct
            assign wr_en   = accept;
            assign wr_data = in_entry;
        end else begin : g_pipe
            localparam int STAGES = LATENCY - 1;

            logic [STAGES-1:0] stg_vld;
            entry_t            stg_data [STAGES];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stg_vld <= '0;
                end else if (flush) begin
                    stg_vld <= '0;
                end else begin
                    stg_vld[0] <= accept;
                    for (int i = 1; i < STAGES; i++) begin
                        stg_vld[i] <= stg_vld[i-1];
                    end
                end
            end

            // NOTE: payload registers carry no reset; only the valid bits
            // decide whether their contents mean anything.
            always_ff @(posedge clk) begin
                stg_data[0] <= in_entry;
                for (int i = 1; i < STAGES; i++) begin
                    stg_data[i] <= stg_data[i-1];
                end
            end

            assign wr_en   = stg_vld[STAGES-1];
            assign wr_data = stg_data[STAGES-1];
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Output queue and delivery tracking
    // -------------------------------------------------------------------------
    entry_t             q_mem [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   q_cnt;
    logic [CNT_W-1:0]   occ;
    logic               rob_done;
    logic               cdb_done;

    entry_t head;
    logic   head_vld;
    logic   need_cdb;
    logic   rob_req;
    logic   cdb_req;
    logic   rob_fire;
    logic   cdb_fire;
    logic   rob_ok;
    logic   cdb_ok;
    logic   pop;
    logic   q_wr;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign head     = q_mem[rd_ptr];
    assign head_vld = (q_cnt != '0);
    assign need_cdb = !head.flags[7];

    assign rob_req  = head_vld && !rob_done;
    assign cdb_req  = head_vld && need_cdb && !cdb_done;

    // Grants are ignored during flush so they cannot touch state being cleared.
    assign rob_fire = rob_req && rob_transmit && !flush;
    assign cdb_fire = cdb_req && cdb_transmit && !flush;

    assign rob_ok   = rob_done || rob_fire;
    assign cdb_ok   = !need_cdb || cdb_done || cdb_fire;
    assign pop      = head_vld && rob_ok && cdb_ok && !flush;
    assign q_wr     = wr_en && !flush;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            occ      <= '0;
            rob_done <= 1'b0;
            cdb_done <= 1'b0;
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_cnt    <= '0;
            occ      <= '0;
            rob_done <= 1'b0;
            cdb_done <= 1'b0;
        end else begin
            if (q_wr) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end

            case ({q_wr, pop})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase

            // Occupancy spans pipeline and queue, so it moves on accept, not
            // on queue write.
            case ({accept, pop})
                2'b10:   occ <= occ + CNT_W'(1);
                2'b01:   occ <= occ - CNT_W'(1);
                default: occ <= occ;
            endcase

            // Delivered bits belong to the current head; a pop hands the next
            // entry a clean slate.
            if (pop) begin
                rob_done <= 1'b0;
                cdb_done <= 1'b0;
            end else begin
                if (rob_fire) begin
                    rob_done <= 1'b1;
                end
                if (cdb_fire) begin
                    cdb_done <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (q_wr) begin
            q_mem[wr_ptr] <= wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: head contents while valid, zero when empty (and so under reset)
    // -------------------------------------------------------------------------
    assign busy             = (occ >= CNT_W'(QDEPTH));
    assign rob_transmit_out = rob_req;
    assign cdb_transmit_out = cdb_req;
    assign robid_out        = head_vld ? head.robid : '0;
    assign flags_out        = head_vld ? head.flags : '0;
    assign wbs_out          = head_vld ? head.wbs   : '0;
    assign value_out        = head_vld ? head.value : '0;
    assign cdb_id           = robid_out;
    assign cdb_val          = value_out;

endmodule

// File: doc/shift_fu_pipe.md
SHIFT_FU_PIPE -- requirements
Module: shift_fu_pipe

Interface
REQ-001 Parameter WIDTH, default 8: data width of operands and result.
REQ-002 Parameter ROBID_W, default 4: ROB tag width.
REQ-003 Parameter LATENCY, default 1, legal range 1..4: number of pipeline stages from accept to queue write.
REQ-004 Parameter QDEPTH, default 2, minimum 1: output queue depth and the cap on in-flight operations.
REQ-005 Port clk, input, 1: the only clock, rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port input_transmit, input, 1: issue valid.
REQ-008 Port operand, input, 8: operation code, with bits [3:0] as the opcode.
REQ-009 Port depvals, input, 2xWIDTH: depvals[1]=a (value), depvals[0]=b (shift amount, unsigned).
REQ-010 Ports wbs (8), flags (8) and robid (ROBID_W), input: sideband carried with the op.
REQ-011 Port flush, input, 1: discard all in-flight and queued ops.
REQ-012 Port cdb_transmit, input, 1: CDB grant.
REQ-013 Ports cdb_transmit_out (1), cdb_id (ROBID_W) and cdb_val (WIDTH), output: CDB request.
REQ-014 Port rob_transmit, input, 1: ROB grant.
REQ-015 Ports rob_transmit_out (1), robid_out (ROBID_W), flags_out (8), wbs_out (8) and value_out (WIDTH), output: ROB request.
REQ-016 Port busy, output, 1: stall to issue.

Function
REQ-017 Opcodes SHALL be: 0 SLL, 1 SRL, 2 SRA, 3 ROL, 4 ROR; any other opcode SHALL give result 0.
REQ-018 For SLL, SRL and SRA, b>=WIDTH SHALL saturate: SLL and SRL give 0, SRA gives WIDTH copies of a[WIDTH-1].
REQ-019 For ROL and ROR, the rotate amount SHALL be b mod WIDTH.
REQ-020 An op SHALL be accepted on a rising edge where input_transmit=1, busy=0 and flush=0; otherwise input_transmit SHALL be ignored.
REQ-021 An op accepted at edge k SHALL be written to the output queue at edge k+LATENCY-1; with LATENCY=1 it is written at the accept edge itself.
REQ-022 The op's result, wbs, flags and robid SHALL travel unchanged with it through the pipeline.
REQ-023 Each queue entry SHALL need ROB delivery, and SHALL also need CDB delivery when its flags[7]=0.
REQ-024 Only the head entry SHALL be presented, and it SHALL remain presented until it pops.
REQ-025 rob_transmit_out SHALL be 1 while the head is valid and not yet ROB-delivered.
REQ-026 cdb_transmit_out SHALL be 1 while the head is valid, has flags[7]=0, and is not yet CDB-delivered.
REQ-027 Delivery to a channel SHALL be recorded at an edge where that channel's request and grant are both 1.
REQ-028 Per-head delivered bits SHALL keep one channel from being sent twice.
REQ-029 The head SHALL pop at the edge where its last required delivery completes; simultaneous CDB and ROB grants SHALL pop the head in one cycle.
REQ-030 After a pop, the next entry SHALL be presented in the following cycle, with its delivered bits cleared.
REQ-031 All data outputs SHALL show head contents when the head is valid and SHALL be 0 when the queue is empty.
REQ-032 The occupancy counter SHALL equal pipeline valids plus queue entries: +1 on accept, -1 on pop, unchanged when both occur.
REQ-033 busy SHALL be 1 exactly when the registered occupancy is >= QDEPTH.
REQ-034 A pop in the current cycle SHALL NOT lower busy until the next cycle.
REQ-035 The busy rule SHALL make queue overflow impossible, and no op SHALL ever be dropped.
REQ-036 The queue pointers SHALL wrap modulo QDEPTH.
REQ-037 On flush, the next edge SHALL clear all pipeline valids, queue entries, delivered bits and occupancy.
REQ-038 A grant arriving in the same cycle as flush SHALL have no effect on unit state.

Reset
REQ-039 While rst=1, all pipeline valids, queue pointers, occupancy and delivered bits SHALL be 0 immediately, without waiting for a clock edge.
REQ-040 While rst=1, all outputs SHALL be 0, including busy.
REQ-041 An op in flight when rst asserts SHALL be lost and SHALL never be emitted.
REQ-042 The first accept SHALL be possible on the first edge after rst deasserts.

Verification (WIDTH=8, LATENCY=1, QDEPTH=2)
REQ-043 Issue SRA, a=0x90, b=2, robid=5, flags=0x00 -> after the accept edge: rob_transmit_out=1, value_out=0xE4, cdb_transmit_out=1, cdb_id=5, cdb_val=0xE4.
REQ-044 Issue ROL a=0x81 b=9 -> 0x03; SLL a=0x81 b=9 -> 0x00; SRA a=0x80 b=200 -> 0xFF; opcode 7 -> 0x00.
REQ-045 Issue with flags=0x80 -> cdb_transmit_out stays 0, and the entry pops on the rob_transmit grant alone.
REQ-046 Hold both grants at 0 and issue 2 ops -> busy=1 and a third input_transmit is ignored. Then grant ROB only -> head stays. Then grant CDB -> head pops, second op presented next cycle, busy=0 one cycle after the pop.
REQ-047 Raise both grants in the same cycle -> head pops in one cycle, with no duplicate CDB or ROB request.
REQ-048 With LATENCY=3, assert rst or flush while two ops are in flight -> all outputs 0 and occupancy 0, and the next issued op emerges after 3 edges with the correct value.
